// File: rtl/rd_burst_requester_pkg.sv
// -----------------------------------------------------------------------------
// rd_burst_requester_pkg
// Shared definitions for the burst read requester: FSM state encoding and
// default widths/limits used by the top and its response FIFO.
// -----------------------------------------------------------------------------
package rd_burst_requester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_LEN_W      = 4;
  localparam int DEF_TIMEOUT    = 15;
  localparam int DEF_FIFO_DEPTH = 2;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int WAIT_W = 8;

endpackage

// File: rtl/rd_burst_requester_resp_fifo.sv
// -----------------------------------------------------------------------------
// rd_burst_requester_resp_fifo
// Small synchronous FIFO buffering read responses toward the consumer.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high flush (empties the FIFO)
//   i_push       write request; ignored when full
//   i_push_data  data written on push
//   o_full       registered count equals FIFO_DEPTH
//   i_pop        read request; ignored when empty
//   o_head       oldest entry, forced to zero while empty
//   o_empty      registered count is zero
// -----------------------------------------------------------------------------
module rd_burst_requester_resp_fifo #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_full,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Zero while empty so the head reads 0 out of reset without resetting storage.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and count, so clearing the array would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/rd_burst_requester.sv
// -----------------------------------------------------------------------------
// rd_burst_requester
// Issues a burst of single-beat reads from a programmed base address toward a
// valid/ready responder, buffers returned data in a response FIFO, and aborts
// with a sticky timeout flag if the responder stalls too long.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start, base_addr, len   burst launch (ignored while busy)
//   valid, addr             request toward responder
//   ready, rdata            responder accept and returned data
//   resp_valid, resp_data   FIFO head toward consumer
//   resp_ready              consumer pop
//   busy, done, timeout     status: not idle / end-of-burst pulse / sticky abort
// -----------------------------------------------------------------------------
module rd_burst_requester
  import rd_burst_requester_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  state_e             r_state;
  state_e             w_next_state;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [LEN_W-1:0]   r_remaining;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_timeout;

  logic               w_valid;
  logic               w_handshake;
  logic               w_fifo_full;
  logic               w_fifo_empty;

  assign w_handshake = w_valid && ready;

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = (len == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        // Registered fullness only: a same-cycle pop cannot raise valid,
        // so there is no combinational path from resp_ready to valid.
        w_valid = !w_fifo_full;
        if (w_handshake) begin
          if (r_remaining == LEN_W'(1)) w_next_state = ST_DONE;
        end else if (w_valid && (r_wait == WAIT_W'(TIMEOUT - 1))) begin
          // This stalled cycle is the TIMEOUT-th one.
          w_next_state = ST_ERR;
        end
      end
      ST_ERR:  w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_wait      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur_addr  <= base_addr;
            r_remaining <= len;
            r_wait      <= '0;
            r_timeout   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (w_handshake) begin
            r_cur_addr  <= r_cur_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            r_wait      <= '0;
          end else if (w_valid) begin
            r_wait <= r_wait + WAIT_W'(1);
          end
          // valid low because the FIFO is full: the wait counter holds.
        end
        ST_ERR:  r_timeout <= 1'b1;
        default: ;
      endcase
    end
  end

  rd_burst_requester_resp_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_handshake),
    .i_push_data (rdata),
    .o_full      (w_fifo_full),
    .i_pop       (resp_ready),
    .o_head      (resp_data),
    .o_empty     (w_fifo_empty)
  );

  assign valid      = w_valid;
  assign addr       = r_cur_addr;
  assign resp_valid = !w_fifo_empty;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_rd_burst_requester.sv
// -----------------------------------------------------------------------------
// tb_rd_burst_requester
// Directed bench for rd_burst_requester. The responder returns rdata = addr ^ 5,
// so every expected response below is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_rd_burst_requester;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] base_addr;
  logic [3:0] len;
  logic       valid;
  logic [3:0] addr;
  logic       ready;
  logic [3:0] rdata;
  logic       resp_valid;
  logic [3:0] resp_data;
  logic       resp_ready;
  logic       busy;
  logic       done;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Event counters sampled on the clock edge (pre-update values).
  int hs_cnt   = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;

  rd_burst_requester dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .valid      (valid),
    .addr       (addr),
    .ready      (ready),
    .rdata      (rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  assign rdata = addr ^ 4'h5;

  always @(posedge clock) begin
    if (valid && ready)           hs_cnt   = hs_cnt + 1;
    if (resp_valid && resp_ready) pop_cnt  = pop_cnt + 1;
    if (done)                     done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive a one-cycle start; returns in the first cycle after acceptance.
  task automatic start_burst(input logic [3:0] b, input logic [3:0] l);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    step();
    start     = 1'b0;
  endtask

  int hs0, pop0, done0;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    ready = 1'b0; resp_ready = 1'b0;
    step(); step();
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_addr", addr, 0);
    reset = 1'b0;
    step();

    // ---- basic burst: base 3, len 3 ----
    ready = 1'b1; resp_ready = 1'b1;
    done0 = done_cnt;
    start_burst(4'h3, 4'd3);
    check("basic_valid0", valid, 1);
    check("basic_addr0", addr, 4'h3);
    check("basic_busy", busy, 1);
    step();
    check("basic_addr1", addr, 4'h4);
    check("basic_data0", resp_data, 4'h6);
    step();
    check("basic_addr2", addr, 4'h5);
    check("basic_data1", resp_data, 4'h1);
    step();
    check("basic_done", done, 1);
    check("basic_valid_off", valid, 0);
    check("basic_data2", resp_data, 4'h0);
    check("basic_timeout", timeout, 0);
    step();
    check("basic_idle_busy", busy, 0);
    check("basic_idle_done", done, 0);
    check("basic_drained", resp_valid, 0);
    check("basic_done_cnt", done_cnt - done0, 1);

    // ---- address wrap: base E, len 3 ----
    start_burst(4'hE, 4'd3);
    check("wrap_addr0", addr, 4'hE);
    step();
    check("wrap_addr1", addr, 4'hF);
    step();
    check("wrap_addr2", addr, 4'h0);
    check("wrap_valid2", valid, 1);
    step();
    check("wrap_done", done, 1);
    step();

    // ---- backpressure: base 0, len 4, consumer stalled ----
    resp_ready = 1'b0;
    hs0 = hs_cnt; pop0 = pop_cnt;
    start_burst(4'h0, 4'd4);
    check("bp_addr0", addr, 4'h0);
    step();
    check("bp_addr1", addr, 4'h1);
    check("bp_head_a", resp_data, 4'h5);
    step();
    check("bp_full_valid", valid, 0);
    check("bp_hs2", hs_cnt - hs0, 2);
    check("bp_head_b", resp_data, 4'h5);
    step();
    check("bp_hold_valid", valid, 0);
    check("bp_hold_addr", addr, 4'h2);
    check("bp_hs_hold", hs_cnt - hs0, 2);
    resp_ready = 1'b1;
    step();
    check("bp_resume_valid", valid, 1);
    check("bp_resume_addr", addr, 4'h2);
    check("bp_head_c", resp_data, 4'h4);
    step();
    check("bp_addr3", addr, 4'h3);
    check("bp_head_d", resp_data, 4'h7);
    step();
    check("bp_done", done, 1);
    check("bp_head_e", resp_data, 4'h6);
    step();
    check("bp_empty", resp_valid, 0);
    check("bp_pops", pop_cnt - pop0, 4);
    check("bp_hs4", hs_cnt - hs0, 4);

    // ---- timeout: len 2, responder never ready ----
    ready = 1'b0;
    done0 = done_cnt;
    start_burst(4'h0, 4'd2);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("to_valid_c%0d", i), valid, 1);
      step();
    end
    check("to_err_valid", valid, 0);
    check("to_err_busy", busy, 1);
    check("to_err_done", done, 0);
    step();
    check("to_done", done, 1);
    check("to_flag", timeout, 1);
    step();
    check("to_sticky", timeout, 1);
    check("to_done_cnt", done_cnt - done0, 1);

    // ---- len 0: clears timeout, done one cycle after start, no valid ----
    hs0 = hs_cnt;
    start_burst(4'h7, 4'd0);
    check("len0_done", done, 1);
    check("len0_valid", valid, 0);
    check("len0_timeout_clr", timeout, 0);
    step();
    check("len0_idle", busy, 0);

    // ---- start mid-burst ignored ----
    ready = 1'b1;
    start_burst(4'h8, 4'd3);
    check("mid_addr0", addr, 4'h8);
    start = 1'b1; base_addr = 4'h0; len = 4'd1;
    step();
    start = 1'b0;
    check("mid_addr1", addr, 4'h9);
    check("mid_not_done", done, 0);
    step();
    check("mid_addr2", addr, 4'hA);
    step();
    check("mid_done", done, 1);
    step();

    // ---- reset mid-burst ----
    resp_ready = 1'b0;
    done0 = done_cnt;
    start_burst(4'h0, 4'd4);
    step();
    check("rmid_one_beat", resp_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rmid_valid", valid, 0);
    check("rmid_resp_valid", resp_valid, 0);
    check("rmid_busy", busy, 0);
    step(); step();
    check("rmid_no_done", done_cnt - done0, 0);
    check("rmid_still_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
